// File: rtl/vga_pic_engine.sv
// Picture compositor: overlays a PIC_W x PIC_H ROM image on a solid background,
// with frame-synchronous window/mode/scroll shadows and a fixed 3-clock latency.
module vga_pic_engine #(
  parameter int          H_SCREEN = 800,
  parameter int          V_SCREEN = 480,
  parameter int          PIC_W    = 160,
  parameter int          PIC_H    = 160,
  parameter int          ADDR_W   = 16,
  parameter logic [23:0] BG_COLOR = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic [9:0]        win_x_in,
  input  logic [9:0]        win_y_in,
  input  logic [1:0]        mode_in,
  input  logic [7:0]        thresh,
  input  logic              scroll_en,
  input  logic              scroll_dir,
  input  logic [3:0]        scroll_step,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rden,
  input  logic [23:0]       rom_q,
  output logic [23:0]       pix_data,
  output logic              in_pic,
  output logic              frame_end
);

  typedef enum logic [1:0] {
    MODE_COLOR = 2'd0,
    MODE_GRAY  = 2'd1,
    MODE_BIN   = 2'd2,
    MODE_INV   = 2'd3
  } mode_t;

  localparam logic [9:0]  X_LAST = 10'(H_SCREEN - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_SCREEN - 1);
  localparam logic [9:0]  WX_MAX = 10'(H_SCREEN - PIC_W);
  localparam logic [9:0]  WY_MAX = 10'(V_SCREEN - PIC_H);
  localparam logic [10:0] PW     = 11'(PIC_W);
  localparam logic [10:0] PH     = 11'(PIC_H);

  logic [9:0] wx, wy, offset;
  mode_t      mode;
  logic       frame_last;

  assign frame_last = (pix_x == X_LAST) && (pix_y == Y_LAST);

  // Wrap-around scroll offset for the next frame, kept within 0..PIC_W-1.
  logic [10:0] off_up;
  logic [9:0]  off_next;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    off_up   = {1'b0, offset} + 11'(scroll_step);
    off_next = offset;
    if (scroll_en) begin
      if (!scroll_dir)
        off_next = (off_up >= PW) ? 10'(off_up - PW) : 10'(off_up);
      else if (offset >= 10'(scroll_step))
        off_next = offset - 10'(scroll_step);
      else
        off_next = 10'({1'b0, offset} + PW - 11'(scroll_step));
    end
  end

  // NOTE: shadows load with non-blocking assignments, so the pipeline stage clocked on the same edge still sees the old window for the last pixel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wx        <= '0;
      wy        <= '0;
      mode      <= MODE_COLOR;
      offset    <= '0;
      frame_end <= 1'b0;
    end else begin
      frame_end <= frame_last;
      if (frame_last) begin
        wx     <= (win_x_in > WX_MAX) ? WX_MAX : win_x_in;
        wy     <= (win_y_in > WY_MAX) ? WY_MAX : win_y_in;
        mode   <= mode_t'(mode_in);
        offset <= off_next;
      end
    end
  end

  // Window hit and image address for the pixel currently presented.
  logic              hit;
  logic [9:0]        rel_x, rel_y, col;
  logic [10:0]       col_sum;
  logic [ADDR_W-1:0] addr_calc;

  always_comb begin
    hit       = (pix_x >= wx) && ({1'b0, pix_x} < ({1'b0, wx} + PW)) &&
                (pix_y >= wy) && ({1'b0, pix_y} < ({1'b0, wy} + PH));
    rel_x     = pix_x - wx;
    rel_y     = pix_y - wy;
    col_sum   = {1'b0, rel_x} + {1'b0, offset};
    col       = (col_sum >= PW) ? 10'(col_sum - PW) : 10'(col_sum);
    addr_calc = ADDR_W'(rel_y) * ADDR_W'(PIC_W) + ADDR_W'(col);
  end

  mode_t mode_s1, mode_s2;
  logic  hit_s2;

  // Colour conversion on the ROM word, using the mode that travelled with the pixel.
  logic [7:0]  r, g, b, gray;
  logic [16:0] gray_sum;
  logic [23:0] pix_next;

  always_comb begin
    {r, g, b} = rom_q;
    gray_sum  = 17'd77 * {9'd0, r} + 17'd150 * {9'd0, g} + 17'd29 * {9'd0, b};
    gray      = 8'(gray_sum >> 8);
    pix_next  = BG_COLOR;
    if (hit_s2) begin
      unique case (mode_s2)
        MODE_COLOR: pix_next = rom_q;
        MODE_GRAY:  pix_next = {gray, gray, gray};
        MODE_BIN:   pix_next = (gray >= thresh) ? 24'hFFFFFF : 24'h000000;
        MODE_INV:   pix_next = ~rom_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rom_addr <= '0;
      rom_rden <= 1'b0;
      mode_s1  <= MODE_COLOR;
      hit_s2   <= 1'b0;
      mode_s2  <= MODE_COLOR;
      pix_data <= BG_COLOR;
      in_pic   <= 1'b0;
    end else begin
      rom_addr <= hit ? addr_calc : '0;
      rom_rden <= hit;
      mode_s1  <= mode;
      hit_s2   <= rom_rden;
      mode_s2  <= mode_s1;
      pix_data <= pix_next;
      in_pic   <= hit_s2;
    end
  end

endmodule

// File: tb/tb_vga_pic_engine.sv
// Directed bench for vga_pic_engine: drives coordinates directly (jumping to the
// last visible pixel to end a frame) against a one-clock synchronous ROM model.
module tb_vga_pic_engine;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  pix_x, pix_y, win_x_in, win_y_in;
  logic [1:0]  mode_in;
  logic [7:0]  thresh;
  logic        scroll_en, scroll_dir;
  logic [3:0]  scroll_step;
  logic [15:0] rom_addr;
  logic        rom_rden;
  logic [23:0] rom_q = 24'h0;
  logic [23:0] pix_data;
  logic        in_pic, frame_end;

  logic        force_en   = 1'b0;
  logic [23:0] force_word = 24'h0;

  int checks = 0;
  int errors = 0;

  vga_pic_engine dut (
    .clk        (clk),
    .rstn       (rstn),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .win_x_in   (win_x_in),
    .win_y_in   (win_y_in),
    .mode_in    (mode_in),
    .thresh     (thresh),
    .scroll_en  (scroll_en),
    .scroll_dir (scroll_dir),
    .scroll_step(scroll_step),
    .rom_addr   (rom_addr),
    .rom_rden   (rom_rden),
    .rom_q      (rom_q),
    .pix_data   (pix_data),
    .in_pic     (in_pic),
    .frame_end  (frame_end)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_word(input logic [15:0] a);
    if (force_en) return force_word;
    return {a[7:0] ^ 8'h5A, a[15:8], a[7:0] + 8'h11};
  endfunction

  always @(posedge clk) if (rom_rden) rom_q <= rom_word(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    pix_x = 10'(x);
    pix_y = 10'(y);
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    pix_x = '0; pix_y = '0;
    win_x_in = '0; win_y_in = '0;
    mode_in = 2'd0; thresh = 8'h00;
    scroll_en = 1'b0; scroll_dir = 1'b0; scroll_step = 4'd0;
    tick();
    tick();
    check("rst_addr", 32'(rom_addr), 32'h0);
    check("rst_rden", 32'(rom_rden), 32'h0);
    check("rst_pix", 32'(pix_data), 32'hFFFFFF);
    check("rst_in_pic", 32'(in_pic), 32'h0);
    check("rst_frame_end", 32'(frame_end), 32'h0);
    rstn = 1'b1;

    // Frame 1 loads window (500,200), mode 0.
    win_x_in = 10'd500; win_y_in = 10'd200;
    pix(799, 479);
    check("frame_end_pulse", 32'(frame_end), 32'h1);
    pix(500, 200);
    check("frame_end_low", 32'(frame_end), 32'h0);
    check("addr_tl", 32'(rom_addr), 32'd0);
    check("rden_tl", 32'(rom_rden), 32'h1);
    pix(499, 200);
    check("rden_left_out", 32'(rom_rden), 32'h0);
    check("addr_left_out", 32'(rom_addr), 32'd0);
    pix(659, 359);
    check("addr_br", 32'(rom_addr), 32'd25599);
    check("pix_tl", 32'(pix_data), 32'h5A0011);
    check("in_pic_tl", 32'(in_pic), 32'h1);
    pix(660, 359);
    check("rden_right_out", 32'(rom_rden), 32'h0);
    check("pix_left_out", 32'(pix_data), 32'hFFFFFF);
    check("in_pic_left_out", 32'(in_pic), 32'h0);
    pix(500, 360);
    check("rden_below_out", 32'(rom_rden), 32'h0);
    check("pix_br", 32'(pix_data), 32'hA56310);
    check("in_pic_br", 32'(in_pic), 32'h1);

    // Colour modes on forced ROM words.
    force_en = 1'b1; force_word = 24'hFF0000; mode_in = 2'd1;
    pix(799, 479); pix(500, 200); pix(300, 100); pix(300, 100);
    check("mode_gray", 32'(pix_data), 32'h4C4C4C);
    mode_in = 2'd2; thresh = 8'h50;
    pix(799, 479); pix(500, 200); pix(300, 100); pix(300, 100);
    check("mode_bin_below", 32'(pix_data), 32'h000000);
    check("mode_bin_in_pic", 32'(in_pic), 32'h1);
    thresh = 8'h4C;
    pix(500, 200); pix(300, 100); pix(300, 100);
    check("mode_bin_equal", 32'(pix_data), 32'hFFFFFF);
    force_word = 24'h123456; mode_in = 2'd3;
    pix(799, 479); pix(500, 200); pix(300, 100); pix(300, 100);
    check("mode_inv", 32'(pix_data), 32'hEDCBA9);

    // Scroll left by 7 for 23 frames: offset 161 mod 160 = 1.
    force_en = 1'b0; mode_in = 2'd0;
    scroll_en = 1'b1; scroll_dir = 1'b0; scroll_step = 4'd7;
    repeat (23) pix(799, 479);
    scroll_en = 1'b0;
    pix(500, 200);
    check("scroll_left_col0", 32'(rom_addr), 32'd1);
    pix(659, 200);
    check("scroll_left_col159", 32'(rom_addr), 32'd0);

    // Scroll right by 3 from offset 1 wraps to 158.
    scroll_en = 1'b1; scroll_dir = 1'b1; scroll_step = 4'd3;
    pix(799, 479);
    scroll_en = 1'b0;
    pix(500, 200);
    check("scroll_right_col0", 32'(rom_addr), 32'd158);
    pix(502, 200);
    check("scroll_right_wrap", 32'(rom_addr), 32'd0);
    pix(799, 479);
    pix(500, 200);
    check("scroll_hold", 32'(rom_addr), 32'd158);

    // Mid-frame requests must not affect the current frame.
    force_en = 1'b1; force_word = 24'h123456;
    win_x_in = 10'd790; mode_in = 2'd3;
    pix(500, 200);
    check("midframe_addr", 32'(rom_addr), 32'd158);
    check("midframe_rden", 32'(rom_rden), 32'h1);
    pix(640, 200);
    check("midframe_addr2", 32'(rom_addr), 32'd138);
    pix(300, 100);
    check("midframe_mode", 32'(pix_data), 32'h123456);
    pix(799, 479);
    pix(640, 200);
    check("clamp_addr", 32'(rom_addr), 32'd158);
    check("clamp_rden", 32'(rom_rden), 32'h1);
    pix(639, 200);
    check("clamp_left_out", 32'(rom_rden), 32'h0);
    pix(799, 200);
    check("clamp_last_col", 32'(rom_addr), 32'd157);
    check("clamp_mode_inv", 32'(pix_data), 32'hEDCBA9);

    // Asynchronous reset in the middle of a window line.
    pix(700, 200);
    pix(701, 200);
    #2 rstn = 1'b0;
    #1;
    check("arst_addr", 32'(rom_addr), 32'h0);
    check("arst_rden", 32'(rom_rden), 32'h0);
    check("arst_pix", 32'(pix_data), 32'hFFFFFF);
    check("arst_in_pic", 32'(in_pic), 32'h0);
    check("arst_frame_end", 32'(frame_end), 32'h0);
    pix(300, 300);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_stale_in_pic", 32'(in_pic), 32'h0);
    end
    pix(5, 2);
    check("post_rst_addr", 32'(rom_addr), 32'd325);
    pix(300, 300); pix(300, 300);
    check("post_rst_mode0", 32'(pix_data), 32'h123456);
    check("post_rst_in_pic", 32'(in_pic), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pic_engine.md
# vga_pic_engine

Parametrised picture compositor for the VGA pixel pipeline. It overlays a PIC_W x PIC_H image, read from an external synchronous ROM, onto a solid background at a window position chosen at run time. It supports four colour modes and continuous horizontal wrap-around scrolling. It sits between the VGA timing generator, which supplies pix_x/pix_y, and the VGA output driver.

## Interface
Parameters:
- H_SCREEN, 800, visible width in pixels
- V_SCREEN, 480, visible height in lines
- PIC_W, 160, image width
- PIC_H, 160, image height
- ADDR_W, 16, ROM address width; PIC_W*PIC_H <= 2^ADDR_W
- BG_COLOR, 24'hFFFFFF, colour outside the window

Ports:
- clk  in  1  pixel clock
- rstn  in  1  reset, asynchronous, active-low
- pix_x  in  10  current pixel column, 0..H_SCREEN-1
- pix_y  in  10  current pixel line, 0..V_SCREEN-1
- win_x_in  in  10  requested window left edge
- win_y_in  in  10  requested window top edge
- mode_in  in  2  0 colour, 1 gray, 2 binary threshold, 3 inverted colour
- thresh  in  8  binary threshold
- scroll_en  in  1  enable per-frame scrolling
- scroll_dir  in  1  0 = image moves left (offset up), 1 = right (offset down)
- scroll_step  in  4  pixels per frame; must be < PIC_W
- rom_addr  out  ADDR_W  ROM read address
- rom_rden  out  1  ROM read enable
- rom_q  in  24  ROM data {R,G,B}, valid one clock after the address is sampled
- pix_data  out  24  composited RGB
- in_pic  out  1  pix_data comes from the image
- frame_end  out  1  one-cycle pulse at the last visible pixel

## Operation
- Frame end: the cycle where pix_x==H_SCREEN-1 and pix_y==V_SCREEN-1. frame_end is registered, so it is high the cycle after that condition.
- Shadow registers wx, wy, mode and offset update only at frame end, so parameters never tear mid-frame.
  - wx = min(win_x_in, H_SCREEN-PIC_W)
  - wy = min(win_y_in, V_SCREEN-PIC_H)
- Offset update at frame end (offset range 0..PIC_W-1):
  - scroll_en=0: offset is held, not cleared.
  - dir 0: offset = offset+step; if the result is >= PIC_W, subtract PIC_W.
  - dir 1: offset = offset-step; if the result is negative, add PIC_W.
- Window hit: wx <= pix_x < wx+PIC_W and wy <= pix_y < wy+PIC_H.
- Address generation:
  - col = (pix_x-wx)+offset, minus PIC_W if the sum is >= PIC_W (one subtract is enough).
  - rom_addr = (pix_y-wy)*PIC_W + col, truncated to ADDR_W.
  - Outside the window, rom_addr holds 0 and rom_rden is 0.
- Colour path, on the ROM data:
  - gray = (77*R + 150*G + 29*B) >> 8, computed in 17-bit unsigned arithmetic.
  - mode 0: {R,G,B}
  - mode 1: {gray,gray,gray}
  - mode 2: gray >= thresh ? FFFFFF : 000000
  - mode 3: ~{R,G,B}
- Outside the window, pix_data = BG_COLOR and in_pic = 0.
- The mode value applied to a pixel is the shadow mode carried alongside that pixel through the pipeline.

## Timing
- Pipeline for a pixel presented on pix_x/pix_y in cycle N:
  - Edge ending N: rom_addr, rom_rden and the window-hit flag are registered.
  - Cycle N+2: rom_q is valid.
  - Edge ending N+2: pix_data and in_pic are registered, so both are valid in cycle N+3.
  - Fixed latency is 3 clocks; the timing generator delays sync/blank by 3.
- The shadow update and the pipeline are independent. The last pixel of a frame still uses the old parameters; pixel (0,0) of the next frame uses the new ones.
- frame_end is high exactly one cycle per frame.
- Reset, asynchronous and valid at any point including mid-frame:
  - rom_addr=0, rom_rden=0, pix_data=BG_COLOR, in_pic=0, frame_end=0
  - wx=0, wy=0, mode=0, offset=0; pipeline flags cleared
  - The first frame after reset shows mode 0 at window (0,0) until the first frame end loads the shadows.
- Window at the screen edge (wx=H_SCREEN-PIC_W): the last image column is pix_x=H_SCREEN-1, with no wrap to the next line.
- Requests beyond the clamp limits are clamped, not rejected.

## Test plan
- Reset, then one frame with win=(500,200), mode 0, no scroll. In frame 2, pixel (500,200) gives rom_addr 0 and (659,359) gives 25599. 3 clocks after each, pix_data equals the ROM model word; (499,200) gives FFFFFF with in_pic 0.
- Mode 1 with ROM word 0xFF0000 -> pix_data 0x4C4C4C. Mode 2 with thresh 0x50 and the same word -> 000000; thresh 0x4C -> FFFFFF. Mode 3 with 0x123456 -> 0xEDCBA9.
- scroll_en=1, dir 0, step 7, starting at offset 0: after 23 frames offset is 1 (161 mod 160). Pixel (wx,wy) reads address 1, and column 159 reads address 0.
- dir 1, step 3, starting at offset 1: the next frame gives offset 158.
- Change win_x_in and mode_in mid-frame -> no change on the current frame's pixels. Request win_x_in=790 -> wx clamps to 640.
- Assert rstn in the middle of a window line -> all outputs take their reset values immediately. After release, no stale in_pic=1 appears.
